uart_rx_frame: RTL and testbench

// - UART receive framer. Sits directly downstream of the Sampling baud generator.
// - Consumes its 16x-oversample tick (BaudOut -> SampleTick) and the raw serial line.
// - Finds start bits, samples each bit at mid-bit, checks parity and stop.
// - Presents the received word with a one-cycle Done strobe and error flags.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_rx_sync.sv | 22 ++
 rtl/uart_rx_frame.sv | 169 ++++++++++++++++
 tb/tb_uart_rx_frame.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM states, parity codes and
// the default oversample ratio.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the raw serial line; resets to the idle (high) level
// so a reset never looks like a start bit.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta     <= 1'b1;
      sync_out <= 1'b1;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive framer: detects start bits, samples each bit at mid-bit using the
// oversample tick, checks parity and stop, and reports the word with a Done strobe.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_tick,
  input  logic                 rx_in,
  input  logic [1:0]           parity_type,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 done,
  output logic                 parity_error,
  output logic                 stop_error,
  output logic                 busy
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  logic rx_sync;

  uart_rx_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (rx_in),
    .sync_out (rx_sync)
  );

  rx_state_t              state, state_n;
  logic [TICK_W-1:0]      tick_cnt, tick_n;
  logic [BIT_W-1:0]       bit_cnt, bit_n;
  logic [DATA_BITS-1:0]   shift, shift_n;
  logic [1:0]             par_type, par_type_n;
  logic                   par_err, par_err_n;
  logic                   armed, armed_n;
  logic [DATA_BITS-1:0]   data_out_n;
  logic                   done_n, parity_error_n, stop_error_n, busy_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      shift        <= '0;
      par_type     <= PAR_NONE;
      par_err      <= 1'b0;
      armed        <= 1'b1;
      data_out     <= '0;
      done         <= 1'b0;
      parity_error <= 1'b0;
      stop_error   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      tick_cnt     <= tick_n;
      bit_cnt      <= bit_n;
      shift        <= shift_n;
      par_type     <= par_type_n;
      par_err      <= par_err_n;
      armed        <= armed_n;
      data_out     <= data_out_n;
      done         <= done_n;
      parity_error <= parity_error_n;
      stop_error   <= stop_error_n;
      busy         <= busy_n;
    end
  end

  // armed blocks re-triggering on a line still held low after a break frame
  always_comb begin
    state_n        = state;
    tick_n         = tick_cnt;
    bit_n          = bit_cnt;
    shift_n        = shift;
    par_type_n     = par_type;
    par_err_n      = par_err;
    armed_n        = armed;
    data_out_n     = data_out;
    done_n         = 1'b0;
    parity_error_n = parity_error;
    stop_error_n   = stop_error;
    busy_n         = busy;

    case (state)
      IDLE: begin
        tick_n = '0;
        if (rx_sync) begin
          armed_n = 1'b1;
        end else if (armed) begin
          state_n        = START;
          par_type_n     = parity_type;
          par_err_n      = 1'b0;
          busy_n         = 1'b1;
          parity_error_n = 1'b0;
          stop_error_n   = 1'b0;
        end
      end
      START: begin
        if (sample_tick) begin
          if (tick_cnt == TICK_MID) begin
            if (!rx_sync) begin
              state_n = DATA;
              tick_n  = '0;
              bit_n   = '0;
            end else begin
              state_n = IDLE;
              busy_n  = 1'b0;
            end
          end else begin
            tick_n = tick_cnt + TICK_W'(1);
          end
        end
      end
      DATA: begin
        if (sample_tick) begin
          if (tick_cnt == TICK_LAST) begin
            tick_n  = '0;
            shift_n = {rx_sync, shift[DATA_BITS-1:1]};
            if (bit_cnt == BIT_LAST) begin
              state_n = (par_type == PAR_ODD || par_type == PAR_EVEN) ? PARITY : STOP;
            end else begin
              bit_n = bit_cnt + BIT_W'(1);
            end
          end else begin
            tick_n = tick_cnt + TICK_W'(1);
          end
        end
      end
      PARITY: begin
        if (sample_tick) begin
          if (tick_cnt == TICK_LAST) begin
            tick_n    = '0;
            state_n   = STOP;
            par_err_n = (par_type == PAR_EVEN) ? (^shift ^ rx_sync) : ~(^shift ^ rx_sync);
          end else begin
            tick_n = tick_cnt + TICK_W'(1);
          end
        end
      end
      STOP: begin
        if (sample_tick) begin
          if (tick_cnt == TICK_LAST) begin
            tick_n         = '0;
            state_n        = IDLE;
            done_n         = 1'b1;
            data_out_n     = shift;
            parity_error_n = par_err;
            stop_error_n   = ~rx_sync;
            busy_n         = 1'b0;
            armed_n        = rx_sync;
          end else begin
            tick_n = tick_cnt + TICK_W'(1);
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: directed frames plus randomized frames
// compared against a bit-level reference model of the UART frame format.
module tb_uart_rx_frame;

  localparam int BIT_CLKS = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sample_tick = 1'b0;
  logic       rx_in = 1'b1;
  logic [1:0] parity_type = 2'b00;
  logic [7:0] data_out;
  logic       done, parity_error, stop_error, busy;

  int checks = 0;
  int errors = 0;

  int         cycle = 0;
  logic [7:0] q_data[$];
  logic       q_perr[$];
  logic       q_serr[$];
  int         q_time[$];
  logic       busy_seen = 1'b0;

  uart_rx_frame dut (
    .clk          (clk),
    .rst          (rst),
    .sample_tick  (sample_tick),
    .rx_in        (rx_in),
    .parity_type  (parity_type),
    .data_out     (data_out),
    .done         (done),
    .parity_error (parity_error),
    .stop_error   (stop_error),
    .busy         (busy)
  );

  always #10 clk = ~clk;

  // 16x oversample tick: one clock high out of every four
  initial begin
    forever begin
      repeat (3) @(negedge clk);
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
    end
  end

  // Capture every Done pulse with the flags presented alongside it
  always @(negedge clk) begin
    cycle = cycle + 1;
    if (done) begin
      q_data.push_back(data_out);
      q_perr.push_back(parity_error);
      q_serr.push_back(stop_error);
      q_time.push_back(cycle);
    end
    if (busy) busy_seen = 1'b1;
  end

  function automatic logic model_perr(input logic [7:0] d, input logic [1:0] ptype, input logic pbit);
    int ones;
    ones = $countones(d) + int'(pbit);
    if (ptype == 2'b01) return (ones % 2) == 0;
    if (ptype == 2'b10) return (ones % 2) == 1;
    return 1'b0;
  endfunction

  task automatic clear_q();
    q_data.delete();
    q_perr.delete();
    q_serr.delete();
    q_time.delete();
  endtask

  task automatic hold_bits(input int n);
    repeat (n * BIT_CLKS) @(negedge clk);
  endtask

  // Drives one frame; leaves the line at the stop-bit level
  task automatic send_frame(input logic [7:0] d, input logic [1:0] ptype, input logic pbit,
                            input logic stopb, input bit scramble);
    parity_type = ptype;
    rx_in = 1'b0;
    hold_bits(1);
    if (scramble) parity_type = 2'($urandom);
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      hold_bits(1);
    end
    if (ptype == 2'b01 || ptype == 2'b10) begin
      rx_in = pbit;
      hold_bits(1);
    end
    rx_in = stopb;
    hold_bits(1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({data_out, done, parity_error, stop_error, busy} !== 12'h000) begin
      errors++;
      $display("[TB] FAIL reset_outputs got %h want 000", {data_out, done, parity_error, stop_error, busy});
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || q_data.size() != 0) begin
      errors++;
      $display("[TB] FAIL idle_after_reset busy=%b dones=%0d want busy=0 dones=0", busy, q_data.size());
    end
  endtask

  task automatic test_directed(input string name, input logic [7:0] d, input logic [1:0] ptype,
                               input logic pbit, input logic stopb);
    logic exp_perr;
    exp_perr = model_perr(d, ptype, pbit);
    clear_q();
    send_frame(d, ptype, pbit, stopb, 1'b0);
    hold_bits(1);
    checks++;
    if (q_data.size() != 1) begin
      errors++;
      $display("[TB] FAIL %s_done_count got %0d want 1", name, q_data.size());
    end
    if (q_data.size() > 0) begin
      checks++;
      if ({q_data[0], q_perr[0], q_serr[0]} !== {d, exp_perr, ~stopb}) begin
        errors++;
        $display("[TB] FAIL %s_result got data=%h perr=%b serr=%b want data=%h perr=%b serr=%b",
                 name, q_data[0], q_perr[0], q_serr[0], d, exp_perr, ~stopb);
      end
    end
  endtask

  task automatic test_stop_error();
    test_directed("break55", 8'h55, 2'b00, 1'b0, 1'b0);
    clear_q();
    hold_bits(5);
    checks++;
    if (q_data.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL held_low_retrigger dones=%0d busy=%b want dones=0 busy=0", q_data.size(), busy);
    end
    rx_in = 1'b1;
    hold_bits(2);
    checks++;
    if (q_data.size() != 0 || data_out !== 8'h55 || stop_error !== 1'b1) begin
      errors++;
      $display("[TB] FAIL after_break dones=%0d data=%h serr=%b want dones=0 data=55 serr=1",
               q_data.size(), data_out, stop_error);
    end
  endtask

  task automatic test_glitch();
    logic [7:0] prev;
    prev = data_out;
    clear_q();
    busy_seen = 1'b0;
    rx_in = 1'b0;
    repeat (12) @(negedge clk);
    rx_in = 1'b1;
    repeat (100) @(negedge clk);
    checks++;
    if (busy_seen !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL glitch_busy seen=%b now=%b want seen=1 now=0", busy_seen, busy);
    end
    checks++;
    if (q_data.size() != 0 || parity_error !== 1'b0 || stop_error !== 1'b0 || data_out !== prev) begin
      errors++;
      $display("[TB] FAIL glitch_state dones=%0d perr=%b serr=%b data=%h want 0 0 0 %h",
               q_data.size(), parity_error, stop_error, data_out, prev);
    end
  endtask

  task automatic test_reset_midframe();
    clear_q();
    parity_type = 2'b00;
    rx_in = 1'b0;
    hold_bits(1);
    rx_in = 1'b1;
    hold_bits(3);
    repeat (32) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || data_out !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_midframe busy=%b done=%b data=%h want 0 0 00", busy, done, data_out);
    end
    @(negedge clk);
    rst = 1'b0;
    hold_bits(7);
    checks++;
    if (q_data.size() != 0) begin
      errors++;
      $display("[TB] FAIL reset_midframe_done got %0d want 0", q_data.size());
    end
    test_directed("after_reset81", 8'h81, 2'b00, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    clear_q();
    send_frame(8'h01, 2'b00, 1'b0, 1'b1, 1'b0);
    send_frame(8'hFE, 2'b00, 1'b0, 1'b1, 1'b0);
    hold_bits(1);
    checks++;
    if (q_data.size() != 2) begin
      errors++;
      $display("[TB] FAIL b2b_count got %0d want 2", q_data.size());
    end
    if (q_data.size() == 2) begin
      checks++;
      if (q_data[0] !== 8'h01 || q_data[1] !== 8'hFE) begin
        errors++;
        $display("[TB] FAIL b2b_data got %h %h want 01 fe", q_data[0], q_data[1]);
      end
      checks++;
      if (q_time[1] - q_time[0] != 10 * BIT_CLKS) begin
        errors++;
        $display("[TB] FAIL b2b_spacing got %0d want %0d", q_time[1] - q_time[0], 10 * BIT_CLKS);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic [1:0] ptype;
    logic       pbit, stopb, exp_perr;
    for (int n = 0; n < 12; n++) begin
      d     = 8'($urandom);
      ptype = 2'($urandom);
      pbit  = 1'($urandom);
      stopb = ($urandom_range(0, 3) != 0);
      exp_perr = model_perr(d, ptype, pbit);
      clear_q();
      send_frame(d, ptype, pbit, stopb, 1'b1);
      rx_in = 1'b1;
      hold_bits(2);
      checks++;
      if (q_data.size() != 1) begin
        errors++;
        $display("[TB] FAIL rand%0d_count got %0d want 1", n, q_data.size());
      end
      if (q_data.size() > 0) begin
        checks++;
        if ({q_data[0], q_perr[0], q_serr[0]} !== {d, exp_perr, ~stopb}) begin
          errors++;
          $display("[TB] FAIL rand%0d got data=%h perr=%b serr=%b want data=%h perr=%b serr=%b (ptype=%b)",
                   n, q_data[0], q_perr[0], q_serr[0], d, exp_perr, ~stopb, ptype);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed("a5_none", 8'hA5, 2'b00, 1'b0, 1'b1);
    rx_in = 1'b1;
    hold_bits(1);
    test_directed("3c_even_bad", 8'h3C, 2'b10, 1'b1, 1'b1);
    hold_bits(1);
    test_directed("3c_odd_ok", 8'h3C, 2'b01, 1'b1, 1'b1);
    hold_bits(1);
    test_stop_error();
    test_glitch();
    test_reset_midframe();
    hold_bits(1);
    test_back_to_back();
    hold_bits(1);
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
